// File: rtl/term_pkg.sv
// Shared types for the pairwise term evaluator.
// Mode encoding matches the in_mode port.
package term_pkg;

  typedef enum logic [1:0] {
    MODE_ANYZERO   = 2'd0,
    MODE_ALLNZ     = 2'd1,
    MODE_FIRSTDIFF = 2'd2,
    MODE_SELECT    = 2'd3
  } mode_e;

endpackage

// File: rtl/term_chan_cmp.sv
// Per-channel flag generator for one a/b operand pair.
// z: both zero, nz: both nonzero, d: operands differ.
module term_chan_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         z,
  output logic         nz,
  output logic         d
);

  // Pure combinational flag extraction.
  always_comb begin
    z  = (a == '0) && (b == '0);
    nz = (a != '0) && (b != '0);
    d  = (a != b);
  end

endmodule

// File: rtl/term_eval_pipe.sv
// Two-stage pipelined pairwise term evaluator.
// S1 registers operands and flags, S2 reduces and registers results.
module term_eval_pipe
  import term_pkg::*;
#(
  parameter int NCH   = 5,
  parameter int W     = 4,
  parameter int CNT_W = 8,
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NCH*W-1:0] in_a,
  input  logic [NCH*W-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic [IDX_W-1:0] in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_idx,
  output logic [W-1:0]     out_data,
  output logic             out_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] hit_cnt
);

  logic r1;
  logic r2;
  logic s2_valid;

  logic [NCH-1:0] z_c;
  logic [NCH-1:0] nz_c;
  logic [NCH-1:0] d_c;

  logic                     s1_valid;
  mode_e                    s1_mode;
  logic [IDX_W-1:0]         s1_sel;
  logic [NCH-1:0][W-1:0]    s1_a;
  logic [NCH-1:0][W-1:0]    s1_b;
  logic [NCH-1:0]           s1_z;
  logic [NCH-1:0]           s1_nz;
  logic [NCH-1:0]           s1_d;

  logic             c_hit;
  logic [IDX_W-1:0] c_idx;
  logic [W-1:0]     c_data;
  logic             c_err;
  logic [31:0]      sel32;
  logic             sel_ok;
  logic             hs;

  for (genvar i = 0; i < NCH; i++) begin : g_cmp
    term_chan_cmp #(
      .W(W)
    ) u_cmp (
      .a  (in_a[i*W +: W]),
      .b  (in_b[i*W +: W]),
      .z  (z_c[i]),
      .nz (nz_c[i]),
      .d  (d_c[i])
    );
  end

  assign r2        = !s2_valid || out_ready;
  assign r1        = !s1_valid || r2;
  assign in_ready  = r1;
  assign out_valid = s2_valid;
  assign hs        = s2_valid && out_ready;

  // Stage 1: capture operands and channel flags on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_ANYZERO;
      s1_sel   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_z     <= '0;
      s1_nz    <= '0;
      s1_d     <= '0;
    end else if (r1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= mode_e'(in_mode);
        s1_sel  <= in_sel;
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_z    <= z_c;
        s1_nz   <= nz_c;
        s1_d    <= d_c;
      end
    end
  end

  assign sel32  = 32'(s1_sel);
  assign sel_ok = sel32 < 32'(NCH);

  // Reduce flags into hit/idx/data/err for the selected mode.
  always_comb begin
    c_hit  = 1'b0;
    c_idx  = '0;
    c_data = '0;
    c_err  = 1'b0;
    unique case (1'b1)
      (s1_mode == MODE_ANYZERO): begin
        c_hit = |s1_z;
        for (int i = NCH-1; i >= 0; i--) begin
          if (s1_z[i]) c_idx = IDX_W'(i);
        end
      end
      (s1_mode == MODE_ALLNZ): begin
        c_hit = &s1_nz;
        for (int i = NCH-1; i >= 0; i--) begin
          if (!s1_nz[i]) c_idx = IDX_W'(i);
        end
      end
      (s1_mode == MODE_FIRSTDIFF): begin
        c_hit = |s1_d;
        for (int i = NCH-1; i >= 0; i--) begin
          if (s1_d[i]) begin
            c_idx  = IDX_W'(i);
            c_data = s1_a[i] ^ s1_b[i];
          end
        end
      end
      (s1_mode == MODE_SELECT): begin
        if (sel_ok) begin
          c_idx = s1_sel;
          for (int i = 0; i < NCH; i++) begin
            if (sel32 == 32'(i)) begin
              c_hit  = s1_d[i];
              c_data = s1_a[i];
            end
          end
        end else begin
          c_err = 1'b1;
        end
      end
    endcase
  end

  // Stage 2: result registers, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_hit  <= 1'b0;
      out_idx  <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else if (r2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_hit  <= c_hit;
        out_idx  <= c_idx;
        out_data <= c_data;
        out_err  <= c_err;
      end
    end
  end

  // Saturating count of consumed hits; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (clr_cnt) begin
      hit_cnt <= '0;
    end else if (hs && out_hit && (hit_cnt != '1)) begin
      hit_cnt <= hit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_term_eval_pipe.sv
// Randomized and directed bench for term_eval_pipe.
// Two instances share inputs; the second has a 2-bit counter.
module tb_term_eval_pipe;
  import term_pkg::*;

  localparam int NCH = 5;
  localparam int W   = 4;
  localparam int IW  = 3;

  typedef struct {
    logic [NCH*W-1:0] a;
    logic [NCH*W-1:0] b;
    logic [1:0]       mode;
    logic [IW-1:0]    sel;
  } txn_t;

  typedef struct {
    logic          hit;
    logic [IW-1:0] idx;
    logic [W-1:0]  data;
    logic          err;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             clr_cnt = 1'b0;
  logic [NCH*W-1:0] in_a = '0;
  logic [NCH*W-1:0] in_b = '0;
  logic [1:0]       in_mode = '0;
  logic [IW-1:0]    in_sel = '0;

  logic          in_ready, out_valid, out_hit, out_err;
  logic [IW-1:0] out_idx;
  logic [W-1:0]  out_data;
  logic [7:0]    hit_cnt;

  logic          in_ready2, out_valid2, out_hit2, out_err2;
  logic [IW-1:0] out_idx2;
  logic [W-1:0]  out_data2;
  logic [1:0]    hit_cnt2;

  txn_t sq[$];
  res_t eq[$];
  int   c8 = 0;
  int   c2 = 0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  term_eval_pipe #(.NCH(NCH), .W(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hit(out_hit), .out_idx(out_idx),
    .out_data(out_data), .out_err(out_err),
    .clr_cnt(clr_cnt), .hit_cnt(hit_cnt)
  );

  term_eval_pipe #(.NCH(NCH), .W(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_sel(in_sel),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_hit(out_hit2), .out_idx(out_idx2),
    .out_data(out_data2), .out_err(out_err2),
    .clr_cnt(clr_cnt), .hit_cnt(hit_cnt2)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t ref_eval(txn_t t);
    res_t r;
    logic [W-1:0] av, bv;
    bit found;
    r.hit = 0; r.idx = 0; r.data = 0; r.err = 0;
    found = 0;
    if (t.mode == 2'd1) r.hit = 1;
    if (t.mode == 2'd3) begin
      if (int'(t.sel) < NCH) begin
        av = t.a[int'(t.sel)*W +: W];
        bv = t.b[int'(t.sel)*W +: W];
        r.hit = (av != bv);
        r.idx = t.sel;
        r.data = av;
      end else begin
        r.err = 1;
      end
      return r;
    end
    for (int i = 0; i < NCH; i++) begin
      av = t.a[i*W +: W];
      bv = t.b[i*W +: W];
      case (t.mode)
        2'd0: if (av == 0 && bv == 0 && !found) begin
          found = 1; r.hit = 1; r.idx = IW'(i);
        end
        2'd1: if ((av == 0 || bv == 0) && !found) begin
          found = 1; r.hit = 0; r.idx = IW'(i);
        end
        default: if (av != bv && !found) begin
          found = 1; r.hit = 1; r.idx = IW'(i); r.data = av ^ bv;
        end
      endcase
    end
    return r;
  endfunction

  task automatic cyc();
    bit acc, hs;
    res_t r;
    if (sq.size() > 0) begin
      in_valid = 1;
      in_a = sq[0].a;
      in_b = sq[0].b;
      in_mode = sq[0].mode;
      in_sel = sq[0].sel;
    end else begin
      in_valid = 0;
    end
    @(negedge clk);
    acc = in_valid && in_ready;
    hs = out_valid && out_ready;
    r.hit = 0;
    if (hs) begin
      chk("no_dup", 32'(eq.size() != 0), 1);
      if (eq.size() != 0) begin
        r = eq.pop_front();
        chk("out_hit", 32'(out_hit), 32'(r.hit));
        chk("out_idx", 32'(out_idx), 32'(r.idx));
        chk("out_data", 32'(out_data), 32'(r.data));
        chk("out_err", 32'(out_err), 32'(r.err));
      end
    end
    if (acc) begin
      eq.push_back(ref_eval(sq[0]));
      void'(sq.pop_front());
    end
    if (clr_cnt) begin
      c8 = 0; c2 = 0;
    end else if (hs && r.hit) begin
      if (c8 < 255) c8++;
      if (c2 < 3) c2++;
    end
    @(posedge clk);
    #1;
    chk("hit_cnt", 32'(hit_cnt), c8);
    chk("hit_cnt_sat", 32'(hit_cnt2), c2);
  endtask

  function automatic txn_t mk(logic [1:0] m, logic [IW-1:0] s);
    txn_t t;
    t.mode = m; t.sel = s; t.a = '0; t.b = '0;
    return t;
  endfunction

  task automatic drain(int lim);
    int n;
    n = 0;
    out_ready = 1;
    while ((sq.size() != 0 || eq.size() != 0) && n < lim) begin
      cyc();
      n++;
    end
    chk("drain_done", 32'(sq.size() + eq.size()), 0);
  endtask

  initial begin
    txn_t t;
    logic [W-1:0] v;

    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_hit_cnt", 32'(hit_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // ANYZERO: only ch2 is zero/zero
    t = mk(2'd0, 0);
    for (int i = 0; i < NCH; i++) begin
      t.a[i*W +: W] = (i == 2) ? 4'h0 : 4'h1;
      t.b[i*W +: W] = (i == 2) ? 4'h0 : 4'h1;
    end
    sq.push_back(t);
    out_ready = 1;
    cyc();
    cyc();
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_hit", 32'(out_hit), 1);
    chk("t1_idx", 32'(out_idx), 2);
    chk("t1_data", 32'(out_data), 0);
    chk("t1_err", 32'(out_err), 0);
    cyc();
    chk("t1_cnt", 32'(hit_cnt), 1);

    // FIRSTDIFF: ch3 and ch4 differ
    t = mk(2'd2, 0);
    for (int i = 0; i < 3; i++) begin
      t.a[i*W +: W] = 4'(i + 6);
      t.b[i*W +: W] = 4'(i + 6);
    end
    t.a[3*W +: W] = 4'hA; t.b[3*W +: W] = 4'h5;
    t.a[4*W +: W] = 4'h1; t.b[4*W +: W] = 4'h0;
    sq.push_back(t);
    cyc();
    cyc();
    chk("t2_hit", 32'(out_hit), 1);
    chk("t2_idx", 32'(out_idx), 3);
    chk("t2_data", 32'(out_data), 32'hF);
    cyc();

    // SELECT illegal, then legal with equal operands
    t = mk(2'd3, 3'd6);
    t.a = '1;
    sq.push_back(t);
    t = mk(2'd3, 3'd4);
    t.a[4*W +: W] = 4'h7; t.b[4*W +: W] = 4'h7;
    sq.push_back(t);
    cyc();
    cyc();
    chk("t3_err", 32'(out_err), 1);
    chk("t3_hit", 32'(out_hit), 0);
    chk("t3_idx", 32'(out_idx), 0);
    cyc();
    chk("t3b_err", 32'(out_err), 0);
    chk("t3b_hit", 32'(out_hit), 0);
    chk("t3b_idx", 32'(out_idx), 4);
    chk("t3b_data", 32'(out_data), 7);
    cyc();

    // Backpressure: three FIRSTDIFF transactions, out stalled
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      t = mk(2'd2, 0);
      t.a[k*W +: W] = 4'(k + 1);
      sq.push_back(t);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k >= 1) begin
        chk("t4_valid", 32'(out_valid), 1);
        chk("t4_stable_idx", 32'(out_idx), 32'(eq[0].idx));
        chk("t4_stable_data", 32'(out_data), 32'(eq[0].data));
      end
    end
    chk("t4_accepted", 32'(sq.size()), 1);
    chk("t4_in_ready", 32'(in_ready), 0);
    drain(20);

    // Counter saturation on the 2-bit instance, then clear
    clr_cnt = 1;
    cyc();
    clr_cnt = 0;
    chk("t5_clr", 32'(hit_cnt2), 0);
    for (int k = 0; k < 5; k++) sq.push_back(mk(2'd0, 0));
    for (int k = 0; k < 7; k++) cyc();
    chk("t5_sat", 32'(hit_cnt2), 3);
    chk("t5_cnt8", 32'(hit_cnt), 5);
    sq.push_back(mk(2'd0, 0));
    cyc();
    cyc();
    clr_cnt = 1;
    cyc();
    clr_cnt = 0;
    chk("t5_clr_wins", 32'(hit_cnt2), 0);
    chk("t5_clr_wins8", 32'(hit_cnt), 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (sq.size() < 2 && ($urandom % 10) < 7) begin
        t = mk(2'($urandom), 3'($urandom));
        for (int i = 0; i < NCH; i++) begin
          v = 4'($urandom);
          t.a[i*W +: W] = ($urandom % 3 == 0) ? 4'h0 : v;
          v = 4'($urandom);
          t.b[i*W +: W] = ($urandom % 3 == 0) ? t.a[i*W +: W] : v;
        end
        sq.push_back(t);
      end
      out_ready = ($urandom % 4) != 0;
      clr_cnt = ($urandom % 40) == 0;
      cyc();
    end
    clr_cnt = 0;
    drain(40);

    // Asynchronous reset with both stages occupied
    out_ready = 0;
    sq.push_back(mk(2'd0, 0));
    sq.push_back(mk(2'd0, 0));
    cyc();
    cyc();
    chk("t6_full", 32'(in_ready), 0);
    #3 rst_n = 0;
    #1;
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_cnt", 32'(hit_cnt), 0);
    chk("t6_hit", 32'(out_hit), 0);
    chk("t6_idx", 32'(out_idx), 0);
    chk("t6_data", 32'(out_data), 0);
    chk("t6_err", 32'(out_err), 0);
    sq.delete();
    eq.delete();
    c8 = 0; c2 = 0;
    in_valid = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    t = mk(2'd1, 0);
    for (int i = 0; i < NCH; i++) begin
      t.a[i*W +: W] = 4'(i + 1);
      t.b[i*W +: W] = 4'(9 - i);
    end
    sq.push_back(t);
    out_ready = 1;
    cyc();
    cyc();
    chk("t6_new_valid", 32'(out_valid), 1);
    chk("t6_new_hit", 32'(out_hit), 1);
    chk("t6_new_idx", 32'(out_idx), 0);
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
